// File: rtl/program_loader.sv
// program_loader: fills instruction memory from a length-prefixed byte stream, then releases the core.
// Define LOADER_CHECKSUM_EN to require and verify a trailing mod-256 checksum byte.
module program_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              core_run,
    output logic              load_err
);

    localparam int unsigned BYTE_W = 8;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   len_q, len_d;
    logic [BYTE_W-1:0]   count_q, count_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [BYTE_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic                core_run_q, core_run_d;
    logic                load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   sum_q, sum_d;
`endif

    logic                ready_state_c;
    logic                accept_c;

    // States that take bytes; LOAD stops taking them once the image is complete.
    always_comb begin
        ready_state_c = 1'b0;
        case (state_q)
            ST_IDLE:  ready_state_c = 1'b1;
            ST_LOAD:  ready_state_c = (count_q != len_q);
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: ready_state_c = 1'b1;
`endif
            default:  ready_state_c = 1'b0;
        endcase
    end

    assign in_ready = ready_state_c & ~reload & Reset;
    assign accept_c = in_valid & in_ready;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_run_d   = 1'b0;
        load_err_d   = load_err_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        if (reload) begin
            state_d    = ST_IDLE;
            count_d    = '0;
            load_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (in_data != 8'd0) begin
                            len_d   = in_data;
                            count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                            sum_d   = '0;
`endif
                            state_d = ST_LOAD;
                        end else begin
                            load_err_d = 1'b1;
                            state_d    = ST_ERROR;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_c) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDR_W'(count_q);
                        imem_wdata_d = in_data;
                        count_d      = count_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum_d        = sum_q + in_data;
`endif
                    end else if (count_q == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept_c) begin
                        if (in_data == sum_q) begin
                            core_run_d = 1'b1;
                            state_d    = ST_RUN;
                        end else begin
                            load_err_d = 1'b1;
                            state_d    = ST_ERROR;
                        end
                    end
                end
`endif
                ST_RUN: begin
                    core_run_d = 1'b1;
                end
                ST_ERROR: begin
                    load_err_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_run_q   <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_run_q   <= core_run_d;
            load_err_q   <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_run   = core_run_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: image-level reference model, queued expected writes, decoupled monitor.
module tb_program_loader;

    localparam int unsigned ADDR_W = 8;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              reload = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              core_run;
    logic              load_err;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .load_err   (load_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] img[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, in the cycle after its accept.
    always @(negedge Clk) begin
        wr_t e;
        if (Reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                         imem_addr, imem_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", 32'(imem_wdata), 32'(e.data));
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, output bit ok);
        int  n;
        logic r;
        n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        while (!ok && n < 20) begin
            @(negedge Clk);
            r = in_ready;
            @(posedge Clk);
            #1;
            ok = r;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 for 20 cycles expected accept of %0h", b);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge Clk);
        check("in_ready_during_reload", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
        reload = 1'b0;
        in_valid = 1'b0;
        @(negedge Clk);
        check("core_run_after_reload", 32'(core_run), 32'd0);
        check("load_err_after_reload", 32'(load_err), 32'd0);
        check("in_ready_after_reload", 32'(in_ready), 32'd1);
        @(posedge Clk);
        #1;
    endtask

    // Streams img (length, bytes, optional checksum) and checks the resulting outcome.
    task automatic run_image(input bit bad_chk, input int gap_max);
        bit         ok;
        logic [7:0] sum;
        sum = 8'd0;
        send(8'(img.size()), ok);
        for (int i = 0; i < img.size(); i++) begin
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
            send(img[i], ok);
            if (ok) exp_q.push_back('{8'(i), img[i], cyc});
            sum = sum + img[i];
        end
`ifdef LOADER_CHECKSUM_EN
        if (gap_max > 0) idle($urandom_range(gap_max, 0));
        send(bad_chk ? 8'(sum + 8'd1) : sum, ok);
        @(negedge Clk);
        check("core_run_after_chk", 32'(core_run), bad_chk ? 32'd0 : 32'd1);
        check("load_err_after_chk", 32'(load_err), bad_chk ? 32'd1 : 32'd0);
        check("in_ready_after_chk", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
`else
        @(negedge Clk);
        check("core_run_t0", 32'(core_run), 32'd0);
        @(negedge Clk);
        check("core_run_t1", 32'(core_run), 32'd0);
        @(negedge Clk);
        check("core_run_t2", 32'(core_run), 32'd1);
        check("load_err_run", 32'(load_err), 32'd0);
        check("in_ready_run", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
        if (bad_chk) begin
            // Extra bytes offered while running must be ignored.
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                in_data = 8'($urandom);
                @(negedge Clk);
                check("in_ready_run_extra", 32'(in_ready), 32'd0);
                @(posedge Clk);
                #1;
            end
            in_valid = 1'b0;
        end
`endif
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        int n;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        #10;
        Reset = 1'b1;
        @(negedge Clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
        @(posedge Clk);
        #1;

        // Basic image at full rate, then random traffic while running, then reload.
        img = '{8'h41, 8'h82, 8'hC5};
        run_image(1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom);
            in_data = 8'($urandom);
            @(negedge Clk);
            check("in_ready_in_run", 32'(in_ready), 32'd0);
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
        pulse_reload();

        // Checksum example: good then corrupted final byte.
        img = '{8'hF0, 8'h20};
        run_image(1'b0, 0);
        pulse_reload();
        run_image(1'b1, 0);
        pulse_reload();

        // Zero length is an error with no writes.
        send(8'h00, ok);
        @(negedge Clk);
        check("zero_len_err", 32'(load_err), 32'd1);
        check("zero_len_run", 32'(core_run), 32'd0);
        check("zero_len_ready", 32'(in_ready), 32'd0);
        @(posedge Clk);
        #1;
        idle(2);
        check("zero_len_err_sticky", 32'(load_err), 32'd1);
        pulse_reload();

        // Reload wins over a simultaneous byte.
        send(8'h04, ok);
        send(8'hAA, ok);
        if (ok) exp_q.push_back('{8'h00, 8'hAA, cyc});
        in_valid = 1'b1;
        in_data = 8'hBB;
        pulse_reload();
        check("reload_one_write", exp_q.size(), 0);
        img = '{8'h55};
        run_image(1'b0, 0);
        pulse_reload();

        // Asynchronous reset in the middle of a load.
        send(8'h05, ok);
        send(8'h11, ok);
        if (ok) exp_q.push_back('{8'h00, 8'h11, cyc});
        send(8'h22, ok);
        if (ok) exp_q.push_back('{8'h01, 8'h22, cyc});
        @(negedge Clk);
        #1;
        check("pre_rst_we", 32'(imem_we), 32'd1);
        in_valid = 1'b1;
        in_data = 8'h33;
        Reset = 1'b0;
        #1;
        check("async_rst_we", 32'(imem_we), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        check("async_rst_run", 32'(core_run), 32'd0);
        in_valid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_image(1'b0, 1);
        pulse_reload();

        // Randomized images, including the length boundaries 1 and 255.
        for (int k = 0; k < 8; k++) begin
            n = (k == 0) ? 1 : (k == 1) ? 255 : int'($urandom_range(16, 2));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            run_image(1'($urandom), (k == 1) ? 0 : 2);
            idle($urandom_range(3, 0));
            pulse_reload();
        end

        idle(3);
        check("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
